// File: rtl/disp_mode_ctrl.sv
// Display scheduler for the 6-digit 7-segment driver: mode FSM, edit blink, alarm alert screen.
// Optional LEADING_ZERO_BLANK_EN hides a zero hour-left digit in CLOCK and ALERT.
module disp_mode_ctrl #(
  parameter int BLINK_HALF_MS    = 500,
  parameter int ALERT_TIMEOUT_MS = 30000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_tick_ms,
  input  logic        i_mode_btn,
  input  logic        i_pos_btn,
  input  logic [23:0] i_time_bcd,
  input  logic [23:0] i_alarm_bcd,
  input  logic [23:0] i_sw_bcd,
  input  logic        i_alarm_ring,
  input  logic        i_alarm_ack,
  output logic [41:0] o_six_digit_seg,
  output logic [5:0]  o_six_dp,
  output logic [1:0]  o_mode,
  output logic [1:0]  o_edit_pos,
  output logic        o_alert
);

  localparam int BW = $clog2(BLINK_HALF_MS + 1);
  localparam int AW = $clog2(ALERT_TIMEOUT_MS + 1);

  typedef enum logic [2:0] {
    CLOCK     = 3'd0,
    SET_TIME  = 3'd1,
    SET_ALARM = 3'd2,
    STOPWATCH = 3'd3,
    ALERT     = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [1:0]    saved, saved_n;
  logic [1:0]    edit, edit_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          bph, bph_n;
  logic [AW-1:0] acnt, acnt_n;
  logic          ring_q;
  logic          rise, set_st;
  logic [23:0]   src;
  logic [41:0]   seg_n;
  logic [5:0]    dp_n;

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  assign rise   = i_alarm_ring & ~ring_q;
  assign set_st = (state == SET_TIME) || (state == SET_ALARM);

  always_comb begin
    state_n = state;
    saved_n = saved;
    edit_n  = edit;
    bcnt_n  = '0;
    bph_n   = 1'b0;
    acnt_n  = '0;
    // blink advances only in SET states and ALERT; every other path clears it
    if ((set_st || state == ALERT) && i_tick_ms) begin
      if (bcnt == BW'(BLINK_HALF_MS - 1)) begin
        bcnt_n = '0;
        bph_n  = ~bph;
      end else begin
        bcnt_n = bcnt + 1'b1;
        bph_n  = bph;
      end
    end else if (set_st || state == ALERT) begin
      bcnt_n = bcnt;
      bph_n  = bph;
    end
    case (state)
      CLOCK, STOPWATCH: begin
        if (rise) begin
          state_n = ALERT;
          saved_n = state[1:0];
        end else if (i_mode_btn) begin
          state_n = (state == CLOCK) ? SET_TIME : CLOCK;
          edit_n  = (state == CLOCK) ? 2'd0 : edit;
        end
      end
      SET_TIME, SET_ALARM: begin
        if (i_mode_btn) begin
          state_n = (state == SET_TIME) ? SET_ALARM : STOPWATCH;
          edit_n  = (state == SET_TIME) ? 2'd0 : edit;
          bcnt_n  = '0;
          bph_n   = 1'b0;
        end else if (i_pos_btn) begin
          edit_n = (edit == 2'd2) ? 2'd0 : edit + 2'd1;
          bcnt_n = '0;
          bph_n  = 1'b0;
        end
      end
      ALERT: begin
        if (i_alarm_ack || i_mode_btn || !i_alarm_ring ||
            (i_tick_ms && acnt == AW'(ALERT_TIMEOUT_MS - 1))) begin
          state_n = state_t'({1'b0, saved});
          bcnt_n  = '0;
          bph_n   = 1'b0;
        end else begin
          acnt_n = i_tick_ms ? acnt + 1'b1 : acnt;
        end
      end
      default: state_n = CLOCK;
    endcase
  end

  always_comb begin
    case (state)
      SET_ALARM: src = i_alarm_bcd;
      STOPWATCH: src = i_sw_bcd;
      default:   src = i_time_bcd;
    endcase
    seg_n = '0;
    for (int i = 0; i < 6; i++)
      seg_n[7*i +: 7] = dec(src[4*i +: 4]);
    if (set_st && bph) begin
      case (edit)
        2'd0:    seg_n[13:0]  = '0;
        2'd1:    seg_n[27:14] = '0;
        default: seg_n[41:28] = '0;
      endcase
    end
`ifdef LEADING_ZERO_BLANK_EN
    if ((state == CLOCK || state == ALERT) && src[23:20] == 4'd0)
      seg_n[41:35] = '0;
`endif
    if (state == ALERT && bph)
      seg_n = '0;
    if (state == STOPWATCH)
      dp_n = 6'b000100;
    else if (state == ALERT && bph)
      dp_n = 6'b000000;
    else
      dp_n = 6'b010100;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= CLOCK;
      saved           <= 2'd0;
      edit            <= 2'd0;
      bcnt            <= '0;
      bph             <= 1'b0;
      acnt            <= '0;
      ring_q          <= 1'b0;
      o_six_digit_seg <= '0;
      o_six_dp        <= '0;
    end else begin
      state           <= state_n;
      saved           <= saved_n;
      edit            <= edit_n;
      bcnt            <= bcnt_n;
      bph             <= bph_n;
      acnt            <= acnt_n;
      ring_q          <= i_alarm_ring;
      o_six_digit_seg <= seg_n;
      o_six_dp        <= dp_n;
    end
  end

  assign o_mode     = (state == ALERT) ? saved : state[1:0];
  assign o_edit_pos = edit;
  assign o_alert    = (state == ALERT);

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Scoreboard bench for disp_mode_ctrl: directed stimulus queues expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_disp_mode_ctrl;

  logic        clk = 0;
  logic        rst_n;
  logic        tick, mode_btn, pos_btn, ring, ack;
  logic [23:0] time_bcd, alarm_bcd, sw_bcd;
  logic [41:0] seg;
  logic [5:0]  dp;
  logic [1:0]  mode, edit;
  logic        alert;

  disp_mode_ctrl #(.BLINK_HALF_MS(4), .ALERT_TIMEOUT_MS(10)) dut (
    .clk(clk), .rst_n(rst_n), .i_tick_ms(tick),
    .i_mode_btn(mode_btn), .i_pos_btn(pos_btn),
    .i_time_bcd(time_bcd), .i_alarm_bcd(alarm_bcd), .i_sw_bcd(sw_bcd),
    .i_alarm_ring(ring), .i_alarm_ack(ack),
    .o_six_digit_seg(seg), .o_six_dp(dp),
    .o_mode(mode), .o_edit_pos(edit), .o_alert(alert)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011;
  localparam logic [6:0] S6 = 7'b1011111, S9 = 7'b1111011, SB = 7'b0000000;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HZ = SB;
`else
  localparam logic [6:0] HZ = S0;
`endif

  localparam logic [41:0] TIME1 = {S1, S2, S3, S4, S5, S6};
  localparam logic [41:0] SW99  = {S0, S0, S0, S0, S9, S9};
  localparam logic [41:0] ALM   = {S0, S6, S5, S4, S3, S2};
  localparam logic [41:0] ALMB  = {S0, S6, SB, SB, S3, S2};
  localparam logic [41:0] TIMEZ = {HZ, SB, S1, S2, S3, S4};

  typedef struct {
    string       name;
    logic [41:0] seg;
    logic [5:0]  dp;
    logic [1:0]  mode;
    logic [1:0]  edit;
    logic        alert;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (seg !== e.seg || dp !== e.dp || mode !== e.mode ||
          edit !== e.edit || alert !== e.alert) begin
        n_fail++;
        $display("FAIL %s: got seg=%h dp=%b mode=%0d edit=%0d alert=%b, want seg=%h dp=%b mode=%0d edit=%0d alert=%b",
                 e.name, seg, dp, mode, edit, alert,
                 e.seg, e.dp, e.mode, e.edit, e.alert);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [41:0] s,
                            input logic [5:0] d, input logic [1:0] m,
                            input logic [1:0] ep, input logic a);
    exp_t e;
    e.name = nm; e.seg = s; e.dp = d; e.mode = m; e.edit = ep; e.alert = a;
    q.push_back(e);
  endtask

  task automatic pulse_mode();
    mode_btn = 1; step(1); mode_btn = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1; step(1); tick = 0;
    end
  endtask

  initial begin
    rst_n = 0; tick = 0; mode_btn = 0; pos_btn = 0; ring = 0; ack = 0;
    time_bcd = 24'h123456; alarm_bcd = 24'h065432; sw_bcd = 24'h000099;
    step(2);
    expect_out("reset", '0, 6'b0, 2'd0, 2'd0, 1'b0);
    rst_n = 1; step(1);
    expect_out("clock_disp", TIME1, 6'b010100, 2'd0, 2'd0, 1'b0);

    pulse_mode(); pulse_mode(); pulse_mode(); step(1);
    expect_out("stopwatch", SW99, 6'b000100, 2'd3, 2'd0, 1'b0);
    pulse_mode(); step(1);
    expect_out("wrap_clock", TIME1, 6'b010100, 2'd0, 2'd0, 1'b0);

    pulse_mode(); pulse_mode();
    pos_btn = 1; step(1); pos_btn = 0; step(1);
    expect_out("set_alarm_pos1", ALM, 6'b010100, 2'd2, 2'd1, 1'b0);
    ticks(4); step(1);
    expect_out("blink_blank", ALMB, 6'b010100, 2'd2, 2'd1, 1'b0);
    ticks(4); step(1);
    expect_out("blink_vis", ALM, 6'b010100, 2'd2, 2'd1, 1'b0);
    mode_btn = 1; pos_btn = 1; step(1); mode_btn = 0; pos_btn = 0; step(1);
    expect_out("mode_beats_pos", SW99, 6'b000100, 2'd3, 2'd1, 1'b0);

    pulse_mode(); step(1);
    ring = 1; step(1);
    expect_out("alert_enter", TIME1, 6'b010100, 2'd0, 2'd1, 1'b1);
    step(1);
    expect_out("alert_vis", TIME1, 6'b010100, 2'd0, 2'd1, 1'b1);
    ticks(4); step(1);
    expect_out("alert_blank", '0, 6'b000000, 2'd0, 2'd1, 1'b1);
    ack = 1; step(1); ack = 0; step(1);
    expect_out("alert_ack", TIME1, 6'b010100, 2'd0, 2'd1, 1'b0);

    ring = 0; step(1); ring = 1; step(1);
    ticks(9);
    expect_out("alert_tick9", TIME1, 6'b010100, 2'd0, 2'd1, 1'b1);
    ticks(1);
    expect_out("alert_timeout", TIME1, 6'b010100, 2'd0, 2'd1, 1'b0);

    ring = 0; pulse_mode();
    ring = 1; step(2);
    expect_out("set_no_alert", TIME1, 6'b010100, 2'd1, 2'd0, 1'b0);
    ring = 0; pulse_mode(); pulse_mode(); step(1);
    ring = 1; step(1);
    expect_out("sw_alert", SW99, 6'b000100, 2'd3, 2'd0, 1'b1);
    rst_n = 0; ring = 0; step(1);
    expect_out("reset_in_alert", '0, 6'b0, 2'd0, 2'd0, 1'b0);
    rst_n = 1; step(1);
    expect_out("after_reset", TIME1, 6'b010100, 2'd0, 2'd0, 1'b0);

    time_bcd = 24'h0F1234; step(1);
    expect_out("lead_zero", TIMEZ, 6'b010100, 2'd0, 2'd0, 1'b0);

    step(3);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
